// File: rtl/tvp_init_sequencer.sv
// tvp_init_sequencer: walks a fixed register table and writes it to the
// video decoder over an I2C master. Define TVP_INIT_READBACK_EN to read back every write.
module tvp_init_sequencer #(
    parameter int NUM_REGS       = 8,
    parameter int MAX_RETRY      = 3,
    parameter int POWERUP_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES = 65_535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    output logic       i2c_start,
    output logic       i2c_rw,
    output logic [7:0] i2c_addr,
    output logic [7:0] i2c_data_in,
    input  logic [7:0] i2c_data_out,
    input  logic       i2c_busy,
    input  logic       i2c_ack_error,
    output logic       done,
    output logic       error,
    output logic [3:0] fail_index
);

    typedef enum logic [3:0] {
        IDLE,
        PWR_WAIT,
        LOAD,
        REQ,
        WAIT_HI,
        WAIT_LO,
        CHECK,
        NEXT,
        DONE,
        FAIL
    } state_e;

    localparam int CNT_MAX = (POWERUP_CYCLES > TIMEOUT_CYCLES) ?
                             POWERUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW_RAW  = $clog2(CNT_MAX + 1);
    localparam int CW      = (CW_RAW < 5) ? 5 : CW_RAW;
    localparam int RTW     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0]  PWR_LAST  = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LAST  = CW'(15);
    localparam logic [3:0]     LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRY);

    state_e         state_q, state_d;
    logic [CW-1:0]  tmr_q, tmr_d;
    logic [3:0]     idx_q, idx_d;
    logic [RTW-1:0] retry_q, retry_d;
    logic           fail_q, fail_d;
    logic           start_q, start_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic [3:0]     fidx_q, fidx_d;
    logic           xfer_bad;
    logic [15:0]    rom_word;

    // {sub-address, value} init table
    function automatic logic [15:0] rom_entry(input logic [3:0] idx);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h00_00;
            4'd1:    w = 16'h02_00;
            4'd2:    w = 16'h03_0D;
            4'd3:    w = 16'h04_3F;
            4'd4:    w = 16'h0D_47;
            4'd5:    w = 16'h0E_04;
            4'd6:    w = 16'h0F_02;
            4'd7:    w = 16'h1B_14;
            default: w = 16'h00_00;
        endcase
        return w;
    endfunction

    assign rom_word = rom_entry(idx_q);

`ifdef TVP_INIT_READBACK_EN
    logic rw_q, rw_d;
    // a read also fails when the returned byte differs from what was written
    assign xfer_bad = i2c_ack_error |
                      (rw_q & (i2c_data_out != wdata_q));
    assign i2c_rw   = rw_q;
`else
    logic unused_data_out;
    assign unused_data_out = ^i2c_data_out;
    assign xfer_bad = i2c_ack_error;
    assign i2c_rw   = 1'b0;
`endif

    assign i2c_start   = start_q;
    assign i2c_addr    = addr_q;
    assign i2c_data_in = wdata_q;
    assign done        = done_q;
    assign error       = error_q;
    assign fail_index  = fidx_q;

    // next-state, counters and registered outputs
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        fail_d  = fail_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fidx_d  = fidx_q;
`ifdef TVP_INIT_READBACK_EN
        rw_d    = rw_q;
`endif
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = PWR_WAIT;
                    tmr_d   = '0;
                end
            end
            PWR_WAIT: begin
                if (tmr_q >= PWR_LAST) begin
                    state_d = LOAD;
                    tmr_d   = '0;
                    idx_d   = '0;
                    retry_d = '0;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            LOAD: begin
                addr_d  = rom_word[15:8];
                wdata_d = rom_word[7:0];
                tmr_d   = '0;
                state_d = REQ;
`ifdef TVP_INIT_READBACK_EN
                rw_d    = 1'b0;
`endif
            end
            REQ: begin
                if (i2c_busy) begin
                    state_d = WAIT_HI;
                    tmr_d   = '0;
                end else if (tmr_q >= TO_LAST) begin
                    state_d = CHECK;
                    fail_d  = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            WAIT_HI: begin
                if (!i2c_busy) begin
                    state_d = CHECK;
                    fail_d  = xfer_bad;
                    tmr_d   = '0;
                end else begin
                    state_d = WAIT_LO;
                    tmr_d   = tmr_q + CW'(1);
                end
            end
            WAIT_LO: begin
                if (!i2c_busy) begin
                    state_d = CHECK;
                    fail_d  = xfer_bad;
                    tmr_d   = '0;
                end else if (tmr_q >= TO_LAST) begin
                    state_d = CHECK;
                    fail_d  = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + CW'(1);
                end
            end
            CHECK: begin
                if (!fail_q) begin
`ifdef TVP_INIT_READBACK_EN
                    if (!rw_q) begin
                        rw_d    = 1'b1;
                        tmr_d   = '0;
                        state_d = REQ;
                    end else begin
                        state_d = NEXT;
                    end
`else
                    state_d = NEXT;
`endif
                end else if (retry_q < RETRY_MAX) begin
                    // the retry gap is counted in place before re-requesting
                    if (tmr_q >= GAP_LAST) begin
                        retry_d = retry_q + RTW'(1);
                        tmr_d   = '0;
                        state_d = REQ;
`ifdef TVP_INIT_READBACK_EN
                        rw_d    = 1'b0;
`endif
                    end else begin
                        tmr_d = tmr_q + CW'(1);
                    end
                end else begin
                    state_d = FAIL;
                    fidx_d  = idx_q;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    retry_d = '0;
                    state_d = LOAD;
                end
            end
            DONE, FAIL: begin
                if (go) begin
                    state_d = PWR_WAIT;
                    tmr_d   = '0;
                    fidx_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        start_d = (state_d == REQ);
        done_d  = (state_d == DONE);
        error_d = (state_d == FAIL);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            fail_q  <= 1'b0;
            start_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            fidx_q  <= '0;
`ifdef TVP_INIT_READBACK_EN
            rw_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            fail_q  <= fail_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            fidx_q  <= fidx_d;
`ifdef TVP_INIT_READBACK_EN
            rw_q    <= rw_d;
`endif
        end
    end

endmodule

// File: tb/tb_tvp_init_sequencer.sv
// tb_tvp_init_sequencer: I2C master stand-in with scripted responses and a
// transaction-level model of the expected init sequence.
module tb_tvp_init_sequencer;

    localparam int NREG = 8;
    localparam int MAXR = 3;
    localparam int PWR  = 10;
    localparam int TO   = 100;
`ifdef TVP_INIT_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       i2c_start;
    logic       i2c_rw;
    logic [7:0] i2c_addr;
    logic [7:0] i2c_data_in;
    logic [7:0] i2c_data_out = 8'h00;
    logic       i2c_busy = 1'b0;
    logic       i2c_ack_error = 1'b0;
    logic       done;
    logic       error;
    logic [3:0] fail_index;

    always #5 clk = ~clk;

    tvp_init_sequencer #(
        .NUM_REGS      (NREG),
        .MAX_RETRY     (MAXR),
        .POWERUP_CYCLES(PWR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .i2c_start    (i2c_start),
        .i2c_rw       (i2c_rw),
        .i2c_addr     (i2c_addr),
        .i2c_data_in  (i2c_data_in),
        .i2c_data_out (i2c_data_out),
        .i2c_busy     (i2c_busy),
        .i2c_ack_error(i2c_ack_error),
        .done         (done),
        .error        (error),
        .fail_index   (fail_index)
    );

    typedef enum int {K_OK, K_NACK, K_TO, K_TOHI, K_LONG, K_BAD} kind_e;
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       rw;
        bit         to;
        bit         gap;
    } txn_t;

    logic [7:0] rom_a [8] = '{8'h00, 8'h02, 8'h03, 8'h04,
                              8'h0D, 8'h0E, 8'h0F, 8'h1B};
    logic [7:0] rom_d [8] = '{8'h00, 8'h00, 8'h0D, 8'h3F,
                              8'h47, 8'h04, 8'h02, 8'h14};

    kind_e wpol [8][4];
    kind_e rpol [8][4];
    int    att [8];
    int    obs_cnt [256];
    txn_t  exp_q [$];
    bit    m_err;
    int    m_idx;
    int    total = 0;
    int    bad = 0;
    bit    armed = 0;
    bit    allow_go = 0;
    int    last_hi = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit fails(input kind_e k);
        return !(k == K_OK || k == K_LONG);
    endfunction

    function automatic int find_e(input logic [7:0] a);
        for (int i = 0; i < NREG; i++)
            if (rom_a[i] == a) return i;
        return 0;
    endfunction

    task automatic set_ok();
        for (int e = 0; e < 8; e++)
            for (int k = 0; k < 4; k++) begin
                wpol[e][k] = K_OK;
                rpol[e][k] = K_OK;
            end
    endtask

    // expected start sequence and outcome, straight from the retry rules
    task automatic build_model();
        bit   fin, ok, f, prev_to;
        txn_t t;
        exp_q.delete();
        m_err = 0;
        m_idx = 0;
        fin = 0;
        prev_to = 0;
        for (int e = 0; e < NREG && !fin; e++) begin
            ok = 0;
            for (int k = 0; k <= MAXR && !ok && !fin; k++) begin
                t = '{rom_a[e], rom_d[e], 1'b0, wpol[e][k] == K_TO, prev_to};
                exp_q.push_back(t);
                prev_to = (wpol[e][k] == K_TO);
                f = fails(wpol[e][k]);
                if (!f && RB == 1) begin
                    t = '{rom_a[e], rom_d[e], 1'b1, rpol[e][k] == K_TO, 1'b0};
                    exp_q.push_back(t);
                    prev_to = (rpol[e][k] == K_TO);
                    f = fails(rpol[e][k]);
                end
                if (!f) ok = 1;
                else if (k == MAXR) begin
                    fin = 1;
                    m_err = 1;
                    m_idx = e;
                end
            end
        end
    endtask

    // master stand-in: answers each start according to the policy tables
    initial begin : master
        int    e, k, hold;
        kind_e kd;
        logic  r;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && i2c_start) begin
                e = find_e(i2c_addr);
                r = i2c_rw;
                if (!r) att[e]++;
                k = att[e] - 1;
                if (k > 3) k = 3;
                if (k < 0) k = 0;
                kd = r ? rpol[e][k] : wpol[e][k];
                if (kd == K_TO) begin
                    hold = 0;
                    while (i2c_start && hold < TO + 50) begin
                        @(posedge clk);
                        #1;
                        hold++;
                    end
                end else begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    i2c_busy = 1'b1;
                    go = allow_go && ($urandom_range(0, 3) == 0);
                    hold = (kd == K_TOHI) ? TO + 5 :
                           (kd == K_LONG) ? 30 : $urandom_range(1, 6);
                    repeat (hold) begin
                        @(posedge clk);
                        #1;
                        go = 1'b0;
                    end
                    i2c_busy = 1'b0;
                    i2c_ack_error = (kd == K_NACK);
                    if (r) i2c_data_out = (kd == K_BAD) ? (rom_d[e] ^ 8'h5A) : rom_d[e];
                    else i2c_data_out = 8'($urandom);
                    @(posedge clk);
                    #1;
                    i2c_ack_error = 1'b0;
                    i2c_data_out = 8'($urandom);
                end
            end
        end
    end

    // per-cycle comparison of DUT outputs against the model
    initial begin : monitor
        logic       ps, pb, sr;
        logic [7:0] sa, sd;
        int         hi_len, lo_len;
        txn_t       cur;
        bit         have;
        ps = 0; pb = 0; sr = 0; sa = 0; sd = 0;
        hi_len = 0; lo_len = 0; have = 0;
        cur = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ps = 0;
                pb = 0;
                have = 0;
                lo_len = 0;
            end else begin
                if (i2c_start && !ps) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_start: addr %0h with no start expected",
                                 i2c_addr);
                        have = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1;
                        chk("txn_addr", i2c_addr, cur.a);
                        chk("txn_data", i2c_data_in, cur.d);
                        chk("txn_rw", i2c_rw, cur.rw);
                        if (cur.gap) chk("retry_gap", lo_len, 16);
                    end
                    obs_cnt[i2c_addr]++;
                    hi_len = 0;
                end
                if (i2c_start) hi_len++;
                if (!i2c_start && ps) begin
                    last_hi = hi_len;
                    if (have && cur.to) chk("timeout_len", hi_len, TO);
                    lo_len = 0;
                end
                if (!i2c_start) lo_len++;
                if (i2c_busy && !pb) begin
                    sa = i2c_addr;
                    sd = i2c_data_in;
                    sr = i2c_rw;
                end else if (i2c_busy) begin
                    chk("busy_addr_stable", i2c_addr, sa);
                    chk("busy_data_stable", i2c_data_in, sd);
                    chk("busy_rw_stable", i2c_rw, sr);
                end
`ifndef TVP_INIT_READBACK_EN
                chk("rw_zero", i2c_rw, 0);
`endif
                if (armed && exp_q.size() > 0) begin
                    chk("done_early", done, 0);
                    chk("error_early", error, 0);
                end
                ps = i2c_start;
                pb = i2c_busy;
            end
        end
    end

    task automatic pulse_go();
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
    endtask

    task automatic run_scn(input string nm);
        int n;
        for (int e = 0; e < 8; e++) att[e] = 0;
        for (int a = 0; a < 256; a++) obs_cnt[a] = 0;
        build_model();
        pulse_go();
        @(negedge clk);
        chk({nm, "_clr_done"}, done, 0);
        chk({nm, "_clr_error"}, error, 0);
        chk({nm, "_clr_fidx"}, fail_index, 0);
        armed = 1;
        n = 0;
        while (!(done || error) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_in_time"}, n < 30000, 1);
        repeat (60) @(negedge clk);
        armed = 0;
        chk({nm, "_done"}, done, !m_err);
        chk({nm, "_error"}, error, m_err);
        chk({nm, "_fidx"}, fail_index, m_err ? m_idx : 0);
        chk({nm, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin : stim
        int n, x;
        set_ok();
        for (int e = 0; e < 8; e++) att[e] = 0;
        for (int a = 0; a < 256; a++) obs_cnt[a] = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start", i2c_start, 0);
        chk("rst_rw", i2c_rw, 0);
        chk("rst_addr", i2c_addr, 0);
        chk("rst_data", i2c_data_in, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_fidx", fail_index, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        set_ok();
        build_model();
        chk("mdl_len", exp_q.size(), 8 * (1 + RB));
        chk("mdl_e2_addr", exp_q[2 * (1 + RB)].a, 8'h03);
        chk("mdl_e7_data", exp_q[7 * (1 + RB)].d, 8'h14);
        run_scn("nominal");
        chk("nominal_done_lit", done, 1);
        chk("nominal_1b_cnt", obs_cnt[8'h1B], 1 + RB);

        set_ok();
        wpol[2][0] = K_NACK;
        wpol[2][1] = K_NACK;
        run_scn("nack2");
        chk("nack2_cnt03", obs_cnt[8'h03], 3 + RB);
        chk("nack2_done_lit", done, 1);

        set_ok();
        for (int k = 0; k < 4; k++) wpol[5][k] = K_NACK;
        run_scn("nack5");
        chk("nack5_cnt0e", obs_cnt[8'h0E], 4);
        chk("nack5_cnt0f", obs_cnt[8'h0F], 0);
        chk("nack5_err_lit", error, 1);
        chk("nack5_fidx_lit", fail_index, 5);

        set_ok();
        for (int k = 0; k < 4; k++) wpol[0][k] = K_TO;
        run_scn("tmo0");
        chk("tmo0_cnt00", obs_cnt[8'h00], 4);
        chk("tmo0_start_len", last_hi, 100);
        chk("tmo0_err_lit", error, 1);
        chk("tmo0_fidx_lit", fail_index, 0);

`ifdef TVP_INIT_READBACK_EN
        set_ok();
        for (int k = 0; k < 4; k++) rpol[2][k] = K_BAD;
        run_scn("rdbk");
        chk("rdbk_cnt03", obs_cnt[8'h03], 8);
        chk("rdbk_fidx_lit", fail_index, 2);
`endif

        set_ok();
        wpol[4][0] = K_LONG;
        for (int e = 0; e < 8; e++) att[e] = 0;
        build_model();
        pulse_go();
        armed = 1;
        n = 0;
        while (!(i2c_busy && i2c_addr == 8'h0D) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach", n < 5000, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        armed = 0;
        #1;
        chk("rst_mid_start", i2c_start, 0);
        chk("rst_mid_rw", i2c_rw, 0);
        chk("rst_mid_addr", i2c_addr, 0);
        chk("rst_mid_data", i2c_data_in, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_error", error, 0);
        chk("rst_mid_fidx", fail_index, 0);
        repeat (40) @(negedge clk);
        rst_n = 1'b1;
        set_ok();
        run_scn("restart");
        chk("restart_cnt00", obs_cnt[8'h00], 1 + RB);

        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < 8; e++)
                for (int k = 0; k < 4; k++) begin
                    x = $urandom_range(0, 99);
                    wpol[e][k] = (x < 8)  ? K_NACK :
                                 (x < 11) ? K_TO   :
                                 (x < 13) ? K_TOHI :
                                 (x < 15) ? K_LONG : K_OK;
                    x = $urandom_range(0, 99);
                    rpol[e][k] = (x < 6)  ? K_NACK :
                                 (x < 9)  ? K_BAD  :
                                 (x < 11) ? K_TO   : K_OK;
                end
            allow_go = 1;
            run_scn("rnd");
            allow_go = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tvp_init_sequencer.md
TVP_INIT_SEQUENCER -- requirements
Module: tvp_init_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 8: number of register-write entries in the init table; legal range 1..16.
REQ-002 Parameter MAX_RETRY, default 3: extra attempts allowed per entry after the first failure.
REQ-003 Parameter POWERUP_CYCLES, default 1_000_000: clk cycles waited after go before the first transaction.
REQ-004 Parameter TIMEOUT_CYCLES, default 65_535: clk cycles allowed per handshake phase before a timeout.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 go  input  1  one-cycle pulse that starts the init sequence.
REQ-008 i2c_start  output  1  transaction request to the I2C master.
REQ-009 i2c_rw  output  1  0 = write, 1 = read.
REQ-010 i2c_addr  output  8  decoder sub-address.
REQ-011 i2c_data_in  output  8  write data.
REQ-012 i2c_data_out  input  8  read data returned by the master.
REQ-013 i2c_busy  input  1  master busy flag.
REQ-014 i2c_ack_error  input  1  master NACK flag.
REQ-015 done  output  1  sequence completed; held high.
REQ-016 error  output  1  sequence aborted; held high.
REQ-017 fail_index  output  4  table index of the aborting entry.

Function
REQ-018 The table SHALL be a fixed ROM of {sub-address, value} pairs, with entries 0..7 = {00,00}, {02,00}, {03,0D}, {04,3F}, {0D,47}, {0E,04}, {0F,02}, {1B,14}; only the first NUM_REGS entries are used.
REQ-019 The FSM SHALL use states IDLE, PWR_WAIT, LOAD, REQ, WAIT_HI, WAIT_LO, CHECK, NEXT, DONE and FAIL.
REQ-020 IDLE -> PWR_WAIT on go; PWR_WAIT SHALL count POWERUP_CYCLES, then -> LOAD with index = 0 and retry count = 0.
REQ-021 LOAD SHALL drive i2c_addr and i2c_data_in from ROM[index] with i2c_rw = 0, then -> REQ.
REQ-022 In REQ, i2c_start SHALL be 1 and held until i2c_busy is sampled high, then -> WAIT_HI and i2c_start = 0 on the same edge; a level hold is required because the master samples start on a divided clock.
REQ-023 WAIT_HI, busy already seen: the FSM SHALL wait for i2c_busy to go low (-> CHECK) and sample i2c_ack_error on that cycle.
REQ-024 If i2c_busy stays high (WAIT_LO) or never rises (REQ) for TIMEOUT_CYCLES, the FSM SHALL treat the attempt as failed.
REQ-025 In CHECK, pass -> NEXT; on a failure, if retry count < MAX_RETRY it SHALL increment the count and -> REQ after a 16-cycle gap; otherwise -> FAIL.
REQ-026 In NEXT, if index = NUM_REGS-1 -> DONE; otherwise index++, retry count = 0, -> LOAD.
REQ-027 DONE SHALL set done = 1; FAIL SHALL set error = 1 and fail_index = index; both states are held until the next go.
REQ-028 A go in DONE or FAIL SHALL clear done, error and fail_index and restart at PWR_WAIT.
REQ-029 A go in any other state SHALL be ignored.
REQ-030 All outputs except i2c_start SHALL remain stable while i2c_busy is high.

Reset
REQ-031 While rst_n is low: state = IDLE; i2c_start, i2c_rw, done and error = 0; i2c_addr, i2c_data_in and fail_index = 0; all counters = 0.
REQ-032 A reset mid-transaction SHALL abandon the transaction immediately; the bus is recovered by the master's own reset.

Configuration
REQ-033 With TVP_INIT_READBACK_EN defined, each passing write SHALL be followed by a read of the same sub-address (i2c_rw = 1, same REQ/WAIT_HI/WAIT_LO handshake).
REQ-034 The read SHALL fail if i2c_ack_error = 1, on timeout, or if i2c_data_out != ROM value; that failure SHALL consume a retry, and the retry SHALL re-issue the write.
REQ-035 Without TVP_INIT_READBACK_EN, no read transactions SHALL be issued and i2c_rw SHALL be constant 0.

Verification
REQ-036 Nominal: POWERUP_CYCLES = 10, master model ACKs all 8 writes -> 8 start/busy handshakes with addr/data matching the ROM in order, then done = 1, error = 0.
REQ-037 NACK retry: entry 2 NACKs twice then ACKs -> 3 transactions at addr 03, sequence completes, done = 1.
REQ-038 Persistent NACK: entry 5 always NACKs, MAX_RETRY = 3 -> exactly 4 attempts at addr 0E, then error = 1, fail_index = 5, no further starts.
REQ-039 Timeout: busy never rises on entry 0, TIMEOUT_CYCLES = 100 -> i2c_start is dropped after 100 cycles and retried; after 4 attempts error = 1, fail_index = 0.
REQ-040 Readback (macro on): model returns 0x00 for addr 03 -> write/read repeats up to 4 times, then fail_index = 2; with a correct model, 16 transactions and done = 1.
REQ-041 Reset/restart: rst_n pulsed low during WAIT_LO of entry 4 -> all outputs at reset values; a following go restarts from entry 0.
